// File: rtl/wb_pkg.sv
// wb_pkg: shared writeback request type, the r0 constant and the write-request qualifier.
package wb_pkg;
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic                 live;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;
  function automatic logic is_write(input logic valid, input logic [WB_ADDR_W-1:0] addr);
    return valid && addr != REG_ZERO;
  endfunction
endpackage

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: MEM/MDU result inputs, register-file write port, forwarding and hazard query.
interface writeback_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int QDEPTH = 4
);
  localparam int CW = $clog2(QDEPTH) + 1;
  logic [ADDR_W-1:0] mem_wb_regdest;
  logic              mem_wb_writereg;
  logic [DATA_W-1:0] mem_wb_wbvalue;
  logic              mdu_wb_valid;
  logic [ADDR_W-1:0] mdu_wb_regdest;
  logic [DATA_W-1:0] mdu_wb_wbvalue;
  logic              mdu_wb_ready;
  logic              wb_reg_en;
  logic [ADDR_W-1:0] wb_reg_addr;
  logic [DATA_W-1:0] wb_reg_data;
  logic              wb_fw_writereg;
  logic [ADDR_W-1:0] wb_fw_regdest;
  logic [DATA_W-1:0] wb_fw_wbvalue;
  logic [ADDR_W-1:0] hz_query_addr;
  logic              hz_pending;
  logic [CW-1:0]     wb_queue_count;
  modport slave (
    input  mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue,
           mdu_wb_valid, mdu_wb_regdest, mdu_wb_wbvalue, hz_query_addr,
    output mdu_wb_ready, wb_reg_en, wb_reg_addr, wb_reg_data,
           wb_fw_writereg, wb_fw_regdest, wb_fw_wbvalue, hz_pending, wb_queue_count
  );
  modport master (
    output mem_wb_regdest, mem_wb_writereg, mem_wb_wbvalue,
           mdu_wb_valid, mdu_wb_regdest, mdu_wb_wbvalue, hz_query_addr,
    input  mdu_wb_ready, wb_reg_en, wb_reg_addr, wb_reg_data,
           wb_fw_writereg, wb_fw_regdest, wb_fw_wbvalue, hz_pending, wb_queue_count
  );
endinterface

// File: rtl/wb_kill_fifo.sv
// wb_kill_fifo: circular queue of MDU results whose entries can be killed in parallel by address.
module wb_kill_fifo
  import wb_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int CW = $clog2(QDEPTH) + 1,
  localparam int PW = $clog2(QDEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  wb_req_t              push_req,
  input  logic                 pop,
  input  logic                 kill_en,
  input  logic [WB_ADDR_W-1:0] kill_addr,
  input  logic [WB_ADDR_W-1:0] match_addr,
  output wb_req_t              head,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 match
);
  wb_req_t       mem_q [QDEPTH];
  wb_req_t       mem_d [QDEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  // Popped slots lose their live bit, so live always implies occupied.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < QDEPTH; i++)
      if (kill_en && mem_q[i].addr == kill_addr) mem_d[i].live = 1'b0;
    if (pop) mem_d[rd_q].live = 1'b0;
    if (push) begin
      mem_d[wr_q] = push_req;
      mem_d[wr_q].live = push_req.live && !(kill_en && push_req.addr == kill_addr);
    end
    rd_d    = rd_q + PW'(pop);
    wr_d    = wr_q + PW'(push);
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < QDEPTH; i++)
      match = match || (mem_q[i].live && mem_q[i].addr == match_addr);
    match = match && match_addr != REG_ZERO;
  end
  assign head  = mem_q[rd_q];
  assign count = count_q;
  assign full  = count_q == CW'(QDEPTH);
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges the never-stalling MEM result and queued MDU results onto one
// register-file write port, MEM first, with same-cycle forwarding and a decode hazard query.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int QDEPTH = 4,
  localparam int CW = $clog2(QDEPTH) + 1
) (
  input logic                clock,
  input logic                reset,
  writeback_arbiter_if.slave bus
);
  wb_req_t           head, push_req;
  logic              mem_sel, head_sel, pop, push, full;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              wb_en_q, wb_en_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  // A live head waits behind MEM; a dead head is discarded regardless.
  always_comb begin
    mem_sel   = is_write(bus.mem_wb_writereg, bus.mem_wb_regdest);
    head_sel  = !mem_sel && count != '0 && head.live;
    pop       = count != '0 && !(mem_sel && head.live);
    push      = is_write(bus.mdu_wb_valid && bus.mdu_wb_ready, bus.mdu_wb_regdest);
    push_req  = '{live: 1'b1, addr: bus.mdu_wb_regdest, data: bus.mdu_wb_wbvalue};
    sel_addr  = mem_sel ? bus.mem_wb_regdest : head.addr;
    sel_data  = mem_sel ? bus.mem_wb_wbvalue : head.data;
    wb_en_d   = mem_sel || head_sel;
    wb_addr_d = wb_en_d ? sel_addr : wb_addr_q;
    wb_data_d = wb_en_d ? sel_data : wb_data_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end
  wb_kill_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_req   (push_req),
    .pop        (pop),
    .kill_en    (mem_sel),
    .kill_addr  (bus.mem_wb_regdest),
    .match_addr (bus.hz_query_addr),
    .head       (head),
    .count      (count),
    .full       (full),
    .match      (bus.hz_pending)
  );
  assign bus.mdu_wb_ready   = !full;
  assign bus.wb_reg_en      = wb_en_q;
  assign bus.wb_reg_addr    = wb_addr_q;
  assign bus.wb_reg_data    = wb_data_q;
  assign bus.wb_fw_writereg = wb_en_d;
  assign bus.wb_fw_regdest  = sel_addr;
  assign bus.wb_fw_wbvalue  = sel_data;
  assign bus.wb_queue_count = count;
endmodule
